rgmii_rx_speed_adapter: RTL

//  RGMII receive-side adapter with 10/100/1000 support. Runs in the PHY receive clock domain.

---
 rtl/rgmii_rx_speed_adapter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/rgmii_rx_speed_adapter.sv
// RGMII receive adapter: turns captured DDR nibble/ctl pairs into a GMII-style byte stream
// for 10/100/1000 operation, tracks in-band link status and keeps frame/error counters.
module rgmii_rx_speed_adapter #(
    parameter int CNT_WIDTH     = 16,
    parameter int STATUS_FILTER = 3
) (
    input  logic                 phy_rx_clk,
    input  logic                 reset,
    input  logic [1:0]           speed_sel,
    input  logic [3:0]           phy_rxd_rising,
    input  logic [3:0]           phy_rxd_falling,
    input  logic                 phy_rx_ctl_rising,
    input  logic                 phy_rx_ctl_falling,
    input  logic                 count_clear,
    output logic [7:0]           mac_rxd,
    output logic                 mac_rx_dv,
    output logic                 mac_rx_er,
    output logic                 mac_crs,
    output logic                 mac_sof,
    output logic                 mac_eof,
    output logic                 mac_align_err,
    output logic                 link_up,
    output logic [1:0]           link_speed,
    output logic                 link_duplex,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] error_count
);

    typedef enum logic [1:0] {IDLE, NIB_HI, NIB_LO} state_e;

    localparam int                   FW       = $clog2(STATUS_FILTER + 1);
    localparam logic [FW-1:0]        FILT_ONE = FW'(1);
    localparam logic [FW-1:0]        FILT_MAX = FW'(STATUS_FILTER);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_e                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [3:0]             nib_q, nib_d;
    logic                   er_acc_q, er_acc_d;
    logic                   first_q, first_d;
    logic                   frame_err_q, frame_err_d;
    logic [7:0]             rxd_q, rxd_d;
    logic                   dv_q, dv_d;
    logic                   er_q, er_d;
    logic                   crs_q, crs_d;
    logic                   sof_q, sof_d;
    logic                   eof_q, eof_d;
    logic                   align_q, align_d;
    logic [3:0]             cand_q, cand_d;
    logic [FW-1:0]          filt_q, filt_d;
    logic [3:0]             status_q, status_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]   error_cnt_q, error_cnt_d;

    logic                   dv, er, gig, nib_match, emit, emit_er, err_end;
    logic [1:0]             mode_eff;
    logic [7:0]             emit_byte;

    assign dv       = phy_rx_ctl_rising;
    assign er       = phy_rx_ctl_rising ^ phy_rx_ctl_falling;
    // A frame runs in the mode seen at its first cycle; mode_q freezes it until IDLE.
    assign mode_eff = (state_q == IDLE) ? speed_sel : mode_q;
    assign gig      = mode_eff[1];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d   = state_q;
        mode_d    = mode_eff;
        nib_d     = nib_q;
        er_acc_d  = er_acc_q;
        first_d   = (state_q == IDLE) ? 1'b1 : first_q;
        emit      = 1'b0;
        emit_byte = '0;
        emit_er   = 1'b0;
        align_d   = 1'b0;
        eof_d     = 1'b0;
        unique case (state_q)
            IDLE, NIB_LO: begin
                if (dv) begin
                    if (gig) begin
                        emit      = 1'b1;
                        emit_byte = {phy_rxd_falling, phy_rxd_rising};
                        emit_er   = er;
                        state_d   = NIB_LO;
                    end else begin
                        nib_d    = phy_rxd_rising;
                        er_acc_d = er;
                        state_d  = NIB_HI;
                    end
                end else if (state_q == NIB_LO) begin
                    eof_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            NIB_HI: begin
                if (dv) begin
                    emit      = 1'b1;
                    emit_byte = {phy_rxd_rising, nib_q};
                    emit_er   = er_acc_q | er;
                    state_d   = NIB_LO;
                end else begin
                    align_d = 1'b1;
                    eof_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (emit) begin
            first_d = 1'b0;
        end
    end

    always_comb begin
        rxd_d       = emit_byte;
        dv_d        = emit;
        er_d        = emit & emit_er;
        sof_d       = emit & ((state_q == IDLE) | first_q);
        frame_err_d = ((state_q == IDLE) ? 1'b0 : frame_err_q) | (dv & er);
        nib_match   = gig ? ({phy_rxd_falling, phy_rxd_rising} inside {8'h0E, 8'h0F, 8'h1F, 8'hFF})
                          : (phy_rxd_rising == 4'hE);
        crs_d       = dv | (~dv & er & nib_match);
    end

    // In-band status: a candidate must repeat over STATUS_FILTER idle cycles in a row.
    always_comb begin
        cand_d   = cand_q;
        filt_d   = filt_q;
        status_d = status_q;
        if (!dv && !er) begin
            if (filt_q != '0 && phy_rxd_rising == cand_q) begin
                filt_d = (filt_q == FILT_MAX) ? FILT_MAX : filt_q + FILT_ONE;
            end else begin
                filt_d = FILT_ONE;
            end
            cand_d = phy_rxd_rising;
            if (filt_d == FILT_MAX) begin
                status_d = phy_rxd_rising;
            end
        end else begin
            filt_d = '0;
        end
    end

    always_comb begin
        err_end     = eof_d & (frame_err_q | align_d);
        frame_cnt_d = frame_cnt_q;
        error_cnt_d = error_cnt_q;
        if (count_clear) begin
            frame_cnt_d = eof_d   ? CNT_ONE : '0;
            error_cnt_d = err_end ? CNT_ONE : '0;
        end else begin
            if (eof_d && frame_cnt_q != CNT_MAX) frame_cnt_d = frame_cnt_q + CNT_ONE;
            if (err_end && error_cnt_q != CNT_MAX) error_cnt_d = error_cnt_q + CNT_ONE;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge phy_rx_clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            nib_q       <= '0;
            er_acc_q    <= 1'b0;
            first_q     <= 1'b0;
            frame_err_q <= 1'b0;
            rxd_q       <= '0;
            dv_q        <= 1'b0;
            er_q        <= 1'b0;
            crs_q       <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            align_q     <= 1'b0;
            cand_q      <= '0;
            filt_q      <= '0;
            status_q    <= '0;
            frame_cnt_q <= '0;
            error_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            nib_q       <= nib_d;
            er_acc_q    <= er_acc_d;
            first_q     <= first_d;
            frame_err_q <= frame_err_d;
            rxd_q       <= rxd_d;
            dv_q        <= dv_d;
            er_q        <= er_d;
            crs_q       <= crs_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            align_q     <= align_d;
            cand_q      <= cand_d;
            filt_q      <= filt_d;
            status_q    <= status_d;
            frame_cnt_q <= frame_cnt_d;
            error_cnt_q <= error_cnt_d;
        end
    end

    assign mac_rxd       = rxd_q;
    assign mac_rx_dv     = dv_q;
    assign mac_rx_er     = er_q;
    assign mac_crs       = crs_q;
    assign mac_sof       = sof_q;
    assign mac_eof       = eof_q;
    assign mac_align_err = align_q;
    assign link_up       = status_q[0];
    assign link_speed    = status_q[2:1];
    assign link_duplex   = status_q[3];
    assign frame_count   = frame_cnt_q;
    assign error_count   = error_cnt_q;

endmodule
